adder_rr_scheduler: RTL and testbench
=====================================

// Module: adder_rr_scheduler
// PURPOSE
//  - Shares one (width+1)-bit adder among n_req requesters. Each requester presents an operand pair (a, b) under its own valid/ready.
//  - A round-robin arbiter grants at most one requester per cycle and registers a + b into a one-entry output stage.
//  - The output stage is tagged with the granted requester index.
//  - Sits between several upstream producers and a single downstream consumer of sums.
// PARAMETERS
//  width  4  operand width in bits; sum is width+1 bits
//  n_req  4  number of requesters, >= 2; need not be a power of 2
//  id_w   $clog2(n_req)  width of the requester tag (localparam)
// PORTS
//  clk        in   1              clock, all logic on posedge
//  rst        in   1              synchronous reset, active-high
//  req_valid  in   n_req          per-requester operand pair valid
//  req_ready  out  n_req          per-requester accept; at most one bit high per cycle
//  req_a      in   n_req*width    packed operand a; requester i at [i*width +: width]
//  req_b      in   n_req*width    packed operand b; requester i at [i*width +: width]
//  sum_valid  out  1              output stage holds a result
//  sum_ready  in   1              downstream accepts the result
//  sum_data   out  width+1        {carry, a + b} of the granted pair
//  sum_id     out  id_w           index of the requester that produced sum_data
// BEHAVIOUR
//  - Reset, applied at any time including mid-operation:
//    - sum_valid=0, sum_data=0, sum_id=0, rr pointer=0.
//    - In-flight result is discarded.
//    - req_ready=0 for all requesters while rst=1.
//  - Accept condition: can_accept = ~sum_valid | sum_ready.
//    - This allows a full-throughput refill in the same cycle as a drain.
//  - Grant selection:
//    - grant = first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping n_req-1 -> 0.
//    - Combinational path from req_valid to req_ready is permitted.
//    - req_valid is never combinationally dependent on req_ready.
//    - req_ready[i] = can_accept & grant_onehot[i].
//  - Transfer on requester i: req_valid[i] & req_ready[i] at a posedge.
//    - Next cycle: sum_valid=1, sum_data=zext(a_i)+zext(b_i), sum_id=i.
//    - ptr <= (i == n_req-1) ? 0 : i+1.
//  - No transfer: ptr unchanged.
//    - An idle cycle does not advance fairness.
//  - Latency: exactly 1 cycle from accepted transfer to sum_valid.
//  - Throughput: 1 sum per cycle when sum_ready is held high.
//  - Downstream handshake:
//    - While sum_valid & ~sum_ready: sum_data and sum_id are held stable and all req_ready=0.
//    - On sum_valid & sum_ready with no new grant: sum_valid <= 0.
//    - sum_data and sum_id may retain their stale values.
//  - Fairness: a continuously valid requester is granted within n_req grants.
//  - Arithmetic: the carry lands in sum_data[width]; no truncation, no saturation.
//    - Example: 4'hF + 4'hF = 5'h1E.
// STRUCTURE
//  - Package adder_sched_pkg:
//    - function clog2_min1 (returns >= 1 for n_req = 1 tools).
//    - Ordering of the packed operand bus.
//  - Sub-module rr_arbiter:
//    - Parameter n; inputs req[n], advance, rst; outputs gnt_onehot[n], gnt_idx.
//    - Holds the pointer; the pointer updates only when advance=1.
//    - Reusable for other shared datapath resources.
//  - Top level: output register, can_accept logic, operand mux by gnt_idx, adder.
// TESTING
//  - Back-to-back:
//    - Stimulus: all 4 req_valid=1, sum_ready=1 for 8 cycles, a_i=i, b_i=1.
//    - Expect: sum_id sequence 0,1,2,3,0,1,2,3; sum_data 1,2,3,4,...; one result per cycle.
//  - Single requester:
//    - Stimulus: only req_valid[2]=1.
//    - Expect: every sum_id=2, no bubbles, ptr stays at 3 between grants.
//  - Backpressure:
//    - Stimulus: sum_ready=0 for 5 cycles after the first result (a=4'hF, b=4'hF).
//    - Expect: sum_data=5'h1E and sum_id stable, all req_ready=0, no sum lost or duplicated.
//  - Wrap/fairness with a non-power-of-2 count:
//    - Stimulus: n_req=3, requesters 0 and 2 valid, ptr at 2.
//    - Expect: grants 2,0,2,0.
//  - Reset mid-operation:
//    - Stimulus: assert rst for 1 cycle while sum_valid=1 and sum_ready=0.
//    - Expect: next cycle sum_valid=0, ptr=0; the next grant goes to the lowest valid index.
//  - Random:
//    - Stimulus: random valids and sum_ready, 1000 transfers.
//    - Check against a per-id scoreboard queue: order is preserved per requester and total counts match.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared helpers for the round-robin adder scheduler
//
// Purpose: sizing helper and packed operand bus layout used by the
//          scheduler top and its arbiter.
// Contents:
//   clog2_min1(n)        ceil(log2(n)), never less than 1, so tags stay legal
//   operand_lsb(i, w)    LSB position of requester i inside a packed bus
package adder_sched_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Requester i occupies bits [i*w +: w] of req_a / req_b.
  function automatic int operand_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with an advance-gated pointer
//
// Purpose: picks the first asserted request starting at the pointer and
//          wrapping n-1 -> 0. The pointer moves past the winner only when
//          advance=1, so idle or stalled cycles do not shift fairness.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset, pointer -> 0
//   req         request vector [n]
//   advance     winner was consumed this cycle
//   gnt_onehot  one-hot grant (all zero when no request)
//   gnt_idx     index of the winner (0 when no request)
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int n = 4,
  localparam int idx_w = clog2_min1(n)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [n-1:0]     req,
  input  logic             advance,
  output logic [n-1:0]     gnt_onehot,
  output logic [idx_w-1:0] gnt_idx
);

  logic [idx_w-1:0] ptr;
  logic [idx_w-1:0] cand_idx;
  logic             found;
  int               cand;

  // Walk ptr, ptr+1, ... modulo n; n need not be a power of two, so the
  // wrap is an explicit subtract rather than relying on index overflow.
  always_comb begin
    found      = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < n; k++) begin
      cand = int'(ptr) + k;
      if (cand >= n) cand = cand - n;
      cand_idx = idx_w'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (found) gnt_onehot[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == idx_w'(n - 1)) ? '0 : gnt_idx + idx_w'(1);
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - one shared adder time-multiplexed among requesters
//
// Purpose: round-robin grants one requester per cycle, adds its operand pair
//          at full width+1 precision and registers the sum, tagged with the
//          requester index, into a one-entry output stage.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req_valid  [n_req] operand pair valid per requester
//   req_ready  [n_req] accept per requester, at most one bit high
//   req_a      [n_req*width] packed operand a, requester i at [i*width +: width]
//   req_b      [n_req*width] packed operand b, same layout
//   sum_valid  output stage holds a result
//   sum_ready  downstream accepts the result
//   sum_data   [width+1] {carry, a + b}
//   sum_id     [id_w] requester that produced sum_data
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int width = 4,
  parameter int n_req = 4,
  localparam int id_w = clog2_min1(n_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*width-1:0] req_a,
  input  logic [n_req*width-1:0] req_b,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [width:0]         sum_data,
  output logic [id_w-1:0]        sum_id
);

  logic             can_accept;
  logic             fire;
  logic [n_req-1:0] gnt_onehot;
  logic [id_w-1:0]  gnt_idx;
  logic [width-1:0] sel_a;
  logic [width-1:0] sel_b;
  logic [width:0]   sum_next;

  // The stage may refill in the same cycle it drains.
  assign can_accept = ~sum_valid | sum_ready;

  // gnt_onehot is nonzero only for an asserted req_valid bit, so any ready
  // bit being high already implies a completed transfer.
  assign req_ready = (rst || !can_accept) ? '0 : gnt_onehot;
  assign fire      = |req_ready;

  rr_arbiter #(
    .n(n_req)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid),
    .advance    (fire),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  assign sel_a    = req_a[operand_lsb(int'(gnt_idx), width) +: width];
  assign sel_b    = req_b[operand_lsb(int'(gnt_idx), width) +: width];
  assign sum_next = {1'b0, sel_a} + {1'b0, sel_b};

  // On a drain without refill only sum_valid drops; data and tag keep their
  // last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_id    <= '0;
    end else if (fire) begin
      sum_valid <= 1'b1;
      sum_data  <= sum_next;
      sum_id    <= gnt_idx;
    end else if (sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - scoreboard bench for the round-robin adder scheduler
module tb_adder_rr_scheduler;
  import adder_sched_pkg::*;

  localparam int W   = 4;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             sum_valid;
  logic             sum_ready;
  logic [W:0]       sum_data;
  logic [IDW-1:0]   sum_id;

  logic [2:0]       v3;
  logic [2:0]       r3;
  logic [3*W-1:0]   a3;
  logic [3*W-1:0]   b3;
  logic             sv3;
  logic             sr3;
  logic [W:0]       sd3;
  logic [1:0]       si3;

  adder_rr_scheduler #(.width(W), .n_req(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_data(sum_data), .sum_id(sum_id)
  );

  adder_rr_scheduler #(.width(W), .n_req(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3),
    .req_a(a3), .req_b(b3), .sum_valid(sv3), .sum_ready(sr3),
    .sum_data(sd3), .sum_id(si3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: output stage occupancy, rr pointer, per-id expected sums.
  logic [W:0] exp_q[N][$];
  int         seen_id[$];
  int         m_ptr = 0;
  bit         m_valid = 1'b0;
  logic [W:0] m_data = '0;
  int         m_id = 0;
  int         pushed = 0;
  int         popped = 0;
  int         discarded = 0;

  int         g;
  int         idx;
  bit         can;
  logic [N-1:0] exp_rdy;
  logic [W:0]   front;

  always @(negedge clk) begin
    // Output side, as it stands before the coming posedge.
    chk("sum_valid", sum_valid, m_valid);
    if (m_valid) begin
      chk("sum_data", sum_data, m_data);
      chk("sum_id", sum_id, m_id);
    end
    chk("ptr", dut.u_arb.ptr, m_ptr);
    if (sum_valid && sum_ready && !rst) begin
      popped++;
      seen_id.push_back(int'(sum_id));
      chk("sb_nonempty", exp_q[sum_id].size() != 0, 1);
      if (exp_q[sum_id].size() != 0) begin
        front = exp_q[sum_id].pop_front();
        chk("sb_order", sum_data, front);
      end
    end

    // Input side: first valid requester from the pointer, wrapping.
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    can = !m_valid || sum_ready;
    exp_rdy = '0;
    if (!rst && can && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);

    // Advance the model to the state after the coming posedge.
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        discarded += exp_q[i].size();
        exp_q[i].delete();
      end
      m_valid = 1'b0;
      m_ptr   = 0;
      m_data  = '0;
      m_id    = 0;
    end else if (exp_rdy != 0) begin
      m_data  = (W+1)'(req_a[g*W +: W]) + (W+1)'(req_b[g*W +: W]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
      exp_q[g].push_back(m_data);
      pushed++;
    end else if (sum_ready) begin
      m_valid = 1'b0;
    end
  end

  int gseq[4] = '{2, 0, 2, 0};
  int target;
  int cyc;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; sum_ready = 1'b1;
    v3 = '0; a3 = '0; b3 = '0; sr3 = 1'b1;
    step(); step();
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_sum_data", sum_data, 0);
    chk("rst_sum_id", sum_id, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;

    // Back-to-back: all valid, a_i=i, b_i=1.
    seen_id.delete();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i);
      req_b[i*W +: W] = W'(1);
    end
    req_valid = '1;
    repeat (8) step();
    req_valid = '0;
    step(); step();
    chk("b2b_count", seen_id.size(), 8);
    for (int i = 0; i < 8 && i < seen_id.size(); i++) chk("b2b_id", seen_id[i], i % N);

    // Single requester 2.
    seen_id.delete();
    req_valid = 4'b0100;
    repeat (6) step();
    req_valid = '0;
    step(); step();
    chk("single_count", seen_id.size(), 6);
    for (int i = 0; i < seen_id.size(); i++) chk("single_id", seen_id[i], 2);

    // Backpressure with carry: F + F.
    seen_id.delete();
    req_a[0 +: W] = 4'hF; req_b[0 +: W] = 4'hF;
    req_valid = 4'b0001;
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    req_valid = '1;
    repeat (5) begin
      #2;
      chk("bp_ready", req_ready, 0);
      chk("bp_data", sum_data, 5'h1E);
      chk("bp_id", sum_id, 0);
      chk("bp_valid", sum_valid, 1);
      step();
    end
    sum_ready = 1'b1;
    req_valid = '0;
    step(); step();
    chk("bp_count", seen_id.size(), 1);

    // Reset while holding a stalled result.
    req_a[0 +: W] = 4'h3; req_b[0 +: W] = 4'h4;
    req_valid = 4'b0001;
    sum_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    #2;
    chk("pre_rst_valid", sum_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b0110;
    #2;
    chk("post_rst_valid", sum_valid, 0);
    chk("post_rst_ptr", dut.u_arb.ptr, 0);
    chk("post_rst_grant", req_ready, 4'b0010);
    sum_ready = 1'b1;
    step();
    req_valid = '0;
    step(); step();

    // Three requesters: 0 and 2 valid with pointer at 2.
    for (int i = 0; i < 3; i++) begin
      a3[i*W +: W] = W'(i + 5);
      b3[i*W +: W] = W'(3);
    end
    v3 = 3'b010;
    #2;
    chk("n3_first", r3, 3'b010);
    step();
    v3 = 3'b101;
    #2;
    chk("n3_ptr", dut3.u_arb.ptr, 2);
    chk("n3_ready", r3, 3'b100);
    for (int j = 0; j < 4; j++) begin
      step();
      #2;
      chk("n3_valid", sv3, 1);
      chk("n3_id", si3, gseq[j]);
      chk("n3_data", sd3, gseq[j] + 8);
      if (j < 3) chk("n3_ready", r3, 3'b001 << gseq[j+1]);
    end
    v3 = '0;
    step();

    // Random traffic until 1000 more transfers.
    target = pushed + 1000;
    cyc = 0;
    while (pushed < target && cyc < 20000) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_a     = (N*W)'($urandom);
      req_b     = (N*W)'($urandom);
      sum_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("random_progress", pushed >= target, 1);
    req_valid = '0;
    sum_ready = 1'b1;
    repeat (3) step();
    chk("total_count", popped + discarded, pushed);
    for (int i = 0; i < N; i++) chk("perid_left", exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
